// File: rtl/fifo_mp.sv
// fifo_mp: multi-port FIFO with all-or-nothing enqueue/dequeue, lookahead read slots,
// flush, free-slot count and sticky protocol-error flag.
module fifo_mp #(
    parameter int data_width_p = 32,
    parameter int els_p        = 16,
    parameter int wr_ports_p   = 2,
    parameter int rd_ports_p   = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 flush_i,
    input  logic [$clog2(wr_ports_p+1)-1:0]      wr_cnt_i,
    input  logic [wr_ports_p*data_width_p-1:0]   wr_data_i,
    input  logic [$clog2(rd_ports_p+1)-1:0]      rd_cnt_i,
    output logic [rd_ports_p*data_width_p-1:0]   rd_data_o,
    output logic [rd_ports_p-1:0]                rd_valid_o,
    output logic [$clog2(els_p+1)-1:0]           count_o,
    output logic [$clog2(els_p+1)-1:0]           free_o,
    output logic                                 err_o
);
    localparam int cw = $clog2(els_p + 1);
    localparam int pw = $clog2(els_p);
    localparam int ww = $clog2(wr_ports_p + 1);
    localparam int rw = $clog2(rd_ports_p + 1);

    logic [data_width_p-1:0] mem [els_p];
    logic [pw-1:0] wr_ptr, rd_ptr;
    logic [cw-1:0] cnt;
    logic          err;
    logic          wr_ok, rd_ok;

    assign count_o = cnt;
    assign free_o  = cw'(els_p) - cnt;
    assign err_o   = err;
    // Both requests are judged against start-of-cycle occupancy; no bypass either way.
    assign wr_ok   = (wr_cnt_i <= ww'(wr_ports_p)) && (cw'(wr_cnt_i) <= free_o);
    assign rd_ok   = (rd_cnt_i <= rw'(rd_ports_p)) && (cw'(rd_cnt_i) <= cnt);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + pw'(wr_cnt_i);
            if (rd_ok) rd_ptr <= rd_ptr + pw'(rd_cnt_i);
            cnt <= cnt + (wr_ok ? cw'(wr_cnt_i) : '0) - (rd_ok ? cw'(rd_cnt_i) : '0);
            if (!wr_ok || !rd_ok) err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i && wr_ok)
            for (int k = 0; k < wr_ports_p; k++)
                if (k < int'(wr_cnt_i)) mem[wr_ptr + pw'(k)] <= wr_data_i[k*data_width_p +: data_width_p];
    end

    for (genvar k = 0; k < rd_ports_p; k++) begin : g_rd
        assign rd_valid_o[k] = cnt > cw'(k);
        assign rd_data_o[k*data_width_p +: data_width_p] = rd_valid_o[k] ? mem[rd_ptr + pw'(k)] : '0;
    end
endmodule

// File: tb/tb_fifo_mp.sv
// tb_fifo_mp: directed and randomized checks of fifo_mp against a queue-based model.
module tb_fifo_mp;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [1:0]  wr_cnt_i = '0;
    logic [63:0] wr_data_i = '0;
    logic [1:0]  rd_cnt_i = '0;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_valid_o;
    logic [4:0]  count_o, free_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];
    logic        m_err = 1'b0;

    fifo_mp dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .wr_cnt_i(wr_cnt_i), .wr_data_i(wr_data_i), .rd_cnt_i(rd_cnt_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .count_o(count_o), .free_o(free_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 64'(count_o), 64'(q.size()));
        chk("free", 64'(free_o), 64'(16 - q.size()));
        for (int k = 0; k < 2; k++) begin
            chk("valid", 64'(rd_valid_o[k]), 64'(q.size() > k));
            chk("data", 64'(rd_data_o[k*32 +: 32]), 64'(q.size() > k ? q[k] : 32'h0));
        end
        chk("err", 64'(err_o), 64'(m_err));
    endtask

    // One clock cycle: drive, let the edge happen, update the model, check at the falling edge.
    task automatic step(input logic fl, input int wc, input logic [31:0] d0, input logic [31:0] d1, input int rc);
        bit wok, rok;
        int sz;
        flush_i = fl;
        wr_cnt_i = 2'(wc);
        wr_data_i = {d1, d0};
        rd_cnt_i = 2'(rc);
        @(posedge clk);
        sz = q.size();
        if (fl) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            wok = wc <= 2 && wc <= 16 - sz;
            rok = rc <= 2 && rc <= sz;
            if (rok) for (int i = 0; i < rc; i++) void'(q.pop_front());
            if (wok) begin
                if (wc > 0) q.push_back(d0);
                if (wc > 1) q.push_back(d1);
            end
            if (!wok || !rok) m_err = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b0;
        wr_cnt_i = '0;
        rd_cnt_i = '0;
        check_all();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        flush_i = 1'b0;
        wr_cnt_i = '0;
        rd_cnt_i = '0;
        @(negedge clk);
        q.delete();
        m_err = 1'b0;
        check_all();
        reset_i = 1'b0;
    endtask

    initial begin
        // 1: fill with 1..16
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 2, 32'(2*i+1), 32'(2*i+2), 0);
        chk("t1_count", 64'(count_o), 64'd16);
        chk("t1_free", 64'(free_o), 64'd0);
        chk("t1_data", rd_data_o, {32'd2, 32'd1});
        chk("t1_valid", 64'(rd_valid_o), 64'b11);
        chk("t1_err", 64'(err_o), 64'd0);
        // 2: full, write 1 + read 2
        step(0, 1, 32'hDEAD, 32'h0, 2);
        chk("t2_count", 64'(count_o), 64'd14);
        chk("t2_data", rd_data_o, {32'd4, 32'd3});
        chk("t2_err", 64'(err_o), 64'd1);
        // 3: over-read of a single entry
        do_reset();
        step(0, 1, 32'hA5, 32'h0, 0);
        step(0, 0, 32'h0, 32'h0, 2);
        chk("t3_count", 64'(count_o), 64'd1);
        chk("t3_valid", 64'(rd_valid_o), 64'b01);
        chk("t3_slot1", 64'(rd_data_o[63:32]), 64'd0);
        chk("t3_slot0", 64'(rd_data_o[31:0]), 64'hA5);
        chk("t3_err", 64'(err_o), 64'd1);
        // 4: streaming across pointer wrap, reads lag by 3 cycles
        do_reset();
        for (int c = 0; c < 23; c++) begin
            step(0, c < 20 ? 2 : 0, $urandom, $urandom, (c >= 3) ? 2 : 0);
            chk("t4_max", 64'(count_o <= 5'd6), 64'd1);
        end
        chk("t4_empty", 64'(count_o), 64'd0);
        chk("t4_err", 64'(err_o), 64'd0);
        // 5: flush with concurrent write/read while err is set
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 2, $urandom, $urandom, 0);
        step(0, 0, 32'h0, 32'h0, 3);
        chk("t5_pre_count", 64'(count_o), 64'd10);
        step(1, 2, $urandom, $urandom, 1);
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_free", 64'(free_o), 64'd16);
        chk("t5_valid", 64'(rd_valid_o), 64'd0);
        chk("t5_err", 64'(err_o), 64'd0);
        // 6: asynchronous reset between edges
        do_reset();
        step(0, 2, 32'h11, 32'h22, 0);
        step(0, 2, 32'h33, 32'h44, 0);
        step(0, 3, 32'h0, 32'h0, 0);
        step(0, 1, 32'h55, 32'h0, 0);
        chk("t6_pre_count", 64'(count_o), 64'd5);
        #1 reset_i = 1'b1;
        #1;
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_data", rd_data_o, 64'd0);
        chk("t6_err", 64'(err_o), 64'd0);
        chk("t6_free", 64'(free_o), 64'd16);
        #1 reset_i = 1'b0;
        q.delete();
        m_err = 1'b0;
        step(0, 2, 32'hBEEF, 32'hCAFE, 0);
        chk("t6_resume", rd_data_o, {32'hCAFE, 32'hBEEF});
        // random traffic including illegal counts and flushes
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
